multicycle_ctrl: RTL

//  Main control FSM of the 16-bit multi-cycle processor. Decodes IR opcode [15:12] and sequences

---
 rtl/multicycle_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 16-bit multi-cycle processor: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
// Optional memory-wait timeout enabled by defining MCTRL_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module multicycle_ctrl
`ifdef MCTRL_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 64
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic [2:0] wb_sel,
   output logic       halted,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP,
      S_IMM_WB,
      S_HALT
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   r_halted;
   logic   r_illegal;
   logic   w_is_illegal;
   logic   w_timeout;

   assign w_is_illegal = (opcode >= 4'd11) && (opcode <= 4'd14);

`ifdef MCTRL_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] r_wait_cnt;

   // Any state change restarts the count, so entry to a wait state always begins at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (w_state_next != r_state) begin
         r_wait_cnt <= '0;
      end else if (!mem_ready) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign w_timeout = !mem_ready && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RST;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_state_next == S_HALT) begin
            r_halted <= 1'b1;
         end
         if ((r_state == S_DECODE) && w_is_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   assign halted  = r_halted;
   assign illegal = r_illegal;

   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'd0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      alu_op       = 2'd0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      wb_sel       = 3'd0;
      case (r_state)
         S_RST: begin
            w_state_next = S_FETCH;
         end
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            if (mem_ready) begin
               ir_write     = 1'b1;
               pc_write     = 1'b1;
               w_state_next = S_DECODE;
            end else if (w_timeout) begin
               w_state_next = S_HALT;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed here into ALU_OUT
            alu_src_b = 2'd2;
            case (opcode)
               4'd0:        w_state_next = S_EXEC_R;
               4'd1, 4'd2:  w_state_next = S_EXEC_I;
               4'd3, 4'd4:  w_state_next = S_MEM_ADDR;
               4'd5, 4'd6:  w_state_next = S_BRANCH;
               4'd7, 4'd8:  w_state_next = S_JUMP;
               4'd9, 4'd10: w_state_next = S_IMM_WB;
               default:     w_state_next = S_HALT;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a    = 1'b1;
            alu_op       = 2'd2;
            w_state_next = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            if (opcode == 4'd2) begin
               alu_src_b = 2'd3;
               alu_op    = 2'd3;
            end else begin
               alu_src_b = 2'd2;
            end
            w_state_next = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write    = 1'b1;
            reg_dst      = (opcode == 4'd0);
            w_state_next = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'd2;
            w_state_next = (opcode == 4'd4) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               w_state_next = S_MEM_WB;
            end else if (w_timeout) begin
               w_state_next = S_HALT;
            end
         end
         S_MEM_WB: begin
            reg_write    = 1'b1;
            wb_sel       = 3'd1;
            w_state_next = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               w_state_next = S_FETCH;
            end else if (w_timeout) begin
               w_state_next = S_HALT;
            end
         end
         S_BRANCH: begin
            alu_src_a    = 1'b1;
            alu_op       = 2'd1;
            pc_src       = 2'd1;
            pc_write     = ((opcode == 4'd5) && zero) || ((opcode == 4'd6) && !zero);
            w_state_next = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            if (opcode == 4'd8) begin
               reg_write = 1'b1;
               wb_sel    = 3'd2;
            end
            w_state_next = S_FETCH;
         end
         S_IMM_WB: begin
            reg_write    = 1'b1;
            wb_sel       = (opcode == 4'd9) ? 3'd3 : 3'd4;
            w_state_next = S_FETCH;
         end
         S_HALT: begin
            w_state_next = S_HALT;
         end
         default: begin
            w_state_next = S_RST;
         end
      endcase
   end

endmodule
